// File: rtl/slow_clk_period_meter.sv
// Synchronises a slow asynchronous square wave, emits edge strobes and measures period/high time.
// Optional PERIOD_METER_AVG_EN adds meas_avg, the mean of the last four measured periods.
module slow_clk_period_meter #(
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned TIMEOUT     = 60000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
`ifdef PERIOD_METER_AVG_EN
    output logic [CNT_W-1:0] meas_avg,
`endif
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_LOST
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_high_latch;

    logic                   w_s;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_take_meas;
    logic                   w_go_lost;

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    // A rise always wins over the timeout that would fire in the same cycle
    assign w_take_meas = r_rise && (r_state == ST_LOW);
    assign w_go_lost   = !r_rise && (r_state != ST_LOST) && (r_cnt == CNT_LAST);

    // Synchroniser, edge detection, counter and measurement FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= '0;
            r_s_prev     <= 1'b0;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_cnt        <= '0;
            r_high_latch <= '0;
            r_state      <= ST_IDLE;
            rise_tick    <= 1'b0;
            fall_tick    <= 1'b0;
            meas_period  <= '0;
            meas_high    <= '0;
            meas_valid   <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_prev   <= w_s;
            r_rise     <= w_s & ~r_s_prev;
            r_fall     <= ~w_s & r_s_prev;
            rise_tick  <= r_rise;
            fall_tick  <= r_fall;
            meas_valid <= w_take_meas;

            if (r_rise) begin
                r_cnt <= '0;
            end else if ((r_state != ST_LOST) && (r_cnt != CNT_MAX)) begin
                r_cnt <= w_cnt_inc;
            end

            case (r_state)
                ST_IDLE, ST_LOST: begin
                    if (r_rise) begin
                        r_state <= ST_HIGH;
                        timeout <= 1'b0;
                    end else if (w_go_lost) begin
                        r_state <= ST_LOST;
                        timeout <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (r_rise) begin
                        r_state <= ST_HIGH;
                    end else if (w_go_lost) begin
                        r_state <= ST_LOST;
                        timeout <= 1'b1;
                    end else if (r_fall) begin
                        r_state      <= ST_LOW;
                        r_high_latch <= w_cnt_inc;
                    end
                end
                ST_LOW: begin
                    if (r_rise) begin
                        r_state     <= ST_HIGH;
                        meas_period <= w_cnt_inc;
                        meas_high   <= r_high_latch;
                    end else if (w_go_lost) begin
                        r_state <= ST_LOST;
                        timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PERIOD_METER_AVG_EN
    localparam int unsigned SUM_W = CNT_W + 2;

    logic [CNT_W-1:0] r_hist [4];
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] w_sum_next;

    // Running sum: drop the oldest entry, add the period being reported
    assign w_sum_next = r_sum - SUM_W'(r_hist[3]) + SUM_W'(w_cnt_inc);

    always_ff @(posedge clk) begin
        if (rst || w_go_lost) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= '0;
            end
            r_sum    <= '0;
            meas_avg <= '0;
        end else if (w_take_meas) begin
            r_hist[0] <= w_cnt_inc;
            for (int i = 1; i < 4; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
            r_sum    <= w_sum_next;
            meas_avg <= CNT_W'(w_sum_next >> 2);
        end
    end
`endif

endmodule

// File: tb/tb_slow_clk_period_meter.sv
// Bench for slow_clk_period_meter: edge-time reference model checked every cycle, table vectors,
// directed latency/timeout/reset/average sequences and randomised square waves.
module tb_slow_clk_period_meter;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMEOUT     = 100;
    localparam int unsigned SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic             rise_tick;
    logic             fall_tick;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_valid;
    logic             timeout;
`ifdef PERIOD_METER_AVG_EN
    logic [CNT_W-1:0] meas_avg;
`endif

    slow_clk_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .rise_tick  (rise_tick),
        .fall_tick  (fall_tick),
        .meas_period(meas_period),
        .meas_high  (meas_high),
        .meas_valid (meas_valid),
`ifdef PERIOD_METER_AVG_EN
        .meas_avg   (meas_avg),
`endif
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: edges are located by edge index; measurements are index differences.
    int       m_n;
    bit [4:0] m_h;
    int       m_t_rise, m_t_fall;
    bit       m_seen_rise, m_have_fall, m_lost;
    bit       e_rise, e_fall, e_valid, e_timeout;
    int       e_period, e_high;
    int       m_q[$];

    int       valid_cnt;
    int       avg_seen[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, m_n, $time);
        end
    endtask

    function automatic int model_avg();
        int s = 0;
        foreach (m_q[i]) s += m_q[i];
        return s / 4;
    endfunction

    // One clock: advance the model with the values the DUT sampled, then compare all outputs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_n = 0; m_h = '0; m_t_rise = 0; m_t_fall = 0;
            m_seen_rise = 0; m_have_fall = 0; m_lost = 0;
            e_rise = 0; e_fall = 0; e_valid = 0; e_timeout = 0;
            e_period = 0; e_high = 0;
            m_q.delete();
        end else begin
            m_n++;
            m_h = {m_h[3:0], sig_in};
            // a level first sampled at edge k shows up as a tick at edge k+SYNC_STAGES+1
            e_rise  = m_h[3] & ~m_h[4];
            e_fall  = ~m_h[3] & m_h[4];
            e_valid = 0;
            if (e_rise) begin
                if (m_have_fall) begin
                    e_valid  = 1;
                    e_period = m_n - m_t_rise;
                    e_high   = m_t_fall - m_t_rise;
                    m_q.push_front(e_period);
                    if (m_q.size() > 4) void'(m_q.pop_back());
                end
                e_timeout = 0; m_lost = 0; m_have_fall = 0; m_seen_rise = 1;
                m_t_rise = m_n;
            end else if (!m_lost && (m_n - m_t_rise == int'(TIMEOUT))) begin
                m_lost = 1; e_timeout = 1; m_have_fall = 0; m_seen_rise = 0;
                m_q.delete();
            end else if (e_fall && m_seen_rise && !m_have_fall) begin
                m_have_fall = 1;
                m_t_fall = m_n;
            end
        end
        #1;
        chk("rise_tick",   32'(rise_tick),   32'(e_rise));
        chk("fall_tick",   32'(fall_tick),   32'(e_fall));
        chk("meas_valid",  32'(meas_valid),  32'(e_valid));
        chk("meas_period", 32'(meas_period), 32'(e_period));
        chk("meas_high",   32'(meas_high),   32'(e_high));
        chk("timeout",     32'(timeout),     32'(e_timeout));
`ifdef PERIOD_METER_AVG_EN
        chk("meas_avg",    32'(meas_avg),    32'(model_avg()));
        if (meas_valid === 1'b1) avg_seen.push_back(int'(meas_avg));
`endif
        if (meas_valid === 1'b1) valid_cnt++;
    endtask

    task automatic drive(input logic v, input int n);
        sig_in = v;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sig_in = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // np full periods followed by one short closing pulse, ending in the low phase
    task automatic periods(input int hi, input int lo, input int np);
        for (int p = 0; p < np; p++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
        drive(1'b1, 1);
        drive(1'b0, 6);
    endtask

    typedef struct {
        int hi;
        int lo;
        int np;
        int exp_period;
        int exp_high;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int k, first, hcnt, to_edge;

        vecs[0] = '{hi: 10, lo: 10, np: 4, exp_period: 20,  exp_high: 10};
        vecs[1] = '{hi: 1,  lo: 6,  np: 3, exp_period: 7,   exp_high: 1};
        vecs[2] = '{hi: 1,  lo: 1,  np: 6, exp_period: 2,   exp_high: 1};
        vecs[3] = '{hi: 3,  lo: 2,  np: 4, exp_period: 5,   exp_high: 3};
        vecs[4] = '{hi: 50, lo: 50, np: 2, exp_period: 100, exp_high: 50};
        vecs[5] = '{hi: 99, lo: 1,  np: 2, exp_period: 100, exp_high: 99};

        // Square-wave table: first rise never measures, every later one does
        foreach (vecs[v]) begin
            do_reset();
            chk("reset_period", 32'(meas_period), 32'd0);
            chk("reset_timeout", 32'(timeout), 32'd0);
            drive(1'b0, 3);
            valid_cnt = 0;
            periods(vecs[v].hi, vecs[v].lo, vecs[v].np);
            chk("tbl_valid_count", 32'(valid_cnt), 32'(vecs[v].np));
            chk("tbl_period", 32'(meas_period), 32'(vecs[v].exp_period));
            chk("tbl_high", 32'(meas_high), 32'(vecs[v].exp_high));
            chk("tbl_timeout", 32'(timeout), 32'd0);
        end

        // Tick latency for a single step in each direction
        do_reset();
        drive(1'b0, 4);
        sig_in = 1'b1;
        k = m_n + 1; first = -1; hcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rise_tick === 1'b1) begin
                if (first < 0) first = m_n;
                hcnt++;
            end
        end
        chk("rise_latency", 32'(first), 32'(k + 3));
        chk("rise_width", 32'(hcnt), 32'd1);
        sig_in = 1'b0;
        k = m_n + 1; first = -1; hcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fall_tick === 1'b1) begin
                if (first < 0) first = m_n;
                hcnt++;
            end
        end
        chk("fall_latency", 32'(first), 32'(k + 3));
        chk("fall_width", 32'(hcnt), 32'd1);

        // Loss of signal, then recovery
        do_reset();
        drive(1'b0, 3);
        drive(1'b1, 10); drive(1'b0, 10);
        drive(1'b1, 10); drive(1'b0, 10);
        k = m_n + 1;
        drive(1'b1, 10);
        sig_in = 1'b0;
        to_edge = -1;
        for (int i = 0; i < 150 && to_edge < 0; i++) begin
            tick();
            if (timeout === 1'b1) to_edge = m_n;
        end
        chk("timeout_edge", 32'(to_edge), 32'(k + 3 + int'(TIMEOUT)));
        chk("lost_period_held", 32'(meas_period), 32'd20);
        chk("lost_high_held", 32'(meas_high), 32'd10);
        valid_cnt = 0;
        drive(1'b1, 10); drive(1'b0, 20);
        drive(1'b1, 1);  drive(1'b0, 6);
        chk("recover_valid_count", 32'(valid_cnt), 32'd1);
        chk("recover_period", 32'(meas_period), 32'd30);
        chk("recover_high", 32'(meas_high), 32'd10);
        chk("recover_timeout", 32'(timeout), 32'd0);

        // Reset in the middle of a low phase
        do_reset();
        drive(1'b0, 3);
        periods(10, 10, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_period", 32'(meas_period), 32'd0);
        chk("midrst_high", 32'(meas_high), 32'd0);
        chk("midrst_valid", 32'(meas_valid), 32'd0);
        valid_cnt = 0;
        drive(1'b0, 3);
        periods(12, 8, 1);
        chk("midrst_valid_count", 32'(valid_cnt), 32'd1);
        chk("midrst_after_period", 32'(meas_period), 32'd20);
        chk("midrst_after_high", 32'(meas_high), 32'd12);

`ifdef PERIOD_METER_AVG_EN
        // Four-period running mean, then cleared by a timeout
        do_reset();
        drive(1'b0, 3);
        avg_seen.delete();
        drive(1'b1, 10); drive(1'b0, 10);
        drive(1'b1, 10); drive(1'b0, 14);
        drive(1'b1, 10); drive(1'b0, 18);
        drive(1'b1, 10); drive(1'b0, 22);
        drive(1'b1, 1);  drive(1'b0, 110);
        chk("avg_count", 32'(avg_seen.size()), 32'd4);
        if (avg_seen.size() == 4) begin
            chk("avg_0", 32'(avg_seen[0]), 32'd5);
            chk("avg_1", 32'(avg_seen[1]), 32'd11);
            chk("avg_2", 32'(avg_seen[2]), 32'd18);
            chk("avg_3", 32'(avg_seen[3]), 32'd26);
        end
        chk("avg_lost_timeout", 32'(timeout), 32'd1);
        chk("avg_lost_cleared", 32'(meas_avg), 32'd0);
`endif

        // Randomised square waves with occasional stalls and resets
        do_reset();
        for (int i = 0; i < 250; i++) begin
            int r, hi, lo;
            r  = int'($urandom_range(0, 19));
            if (r == 0) do_reset();
            hi = (r == 1) ? 105 : int'($urandom_range(1, 40));
            lo = (r == 2) ? 110 : int'($urandom_range(1, 40));
            drive(1'b1, hi);
            drive(1'b0, lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
